// File: rtl/jam_pkg.sv
// Shared types and constant functions for the exhaustive job-assignment solver.
package jam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic longint unsigned factorial(input int unsigned n);
        longint unsigned f;
        f = 1;
        for (int unsigned i = 2; i <= n; i++) f = f * longint'(i);
        return f;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of an N-element permutation; flags the last one.
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0][IDX_W-1:0] seq,
    output logic [N-1:0][IDX_W-1:0] seq_next,
    output logic                    last
);

    int unsigned      p, q, s;
    logic [IDX_W-1:0] pv, qv, sv;

    always_comb begin
        seq_next = seq;
        last     = 1'b1;
        p        = 0;
        q        = 0;
        s        = 0;
        pv       = '0;
        qv       = '0;
        sv       = '0;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (seq[i] < seq[i+1]) begin
                p    = i;
                last = 1'b0;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (i == p) pv = seq[i];
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (i > p && seq[i] > pv) q = i;
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (i == q) qv = seq[i];
        end
        // Swap p/q and reverse the tail in one pass: slot i>p reads the swapped value at N+p-i.
        for (int unsigned i = 0; i < N; i++) begin
            if (i == p) begin
                seq_next[i] = qv;
            end else if (i > p) begin
                s  = N + p - i;
                sv = '0;
                for (int unsigned m = 0; m < N; m++) begin
                    if (m == s) sv = (m == q) ? pv : seq[m];
                end
                seq_next[i] = sv;
            end
        end
    end

endmodule

// File: rtl/jam_search.sv
// Exhaustive N x N job-assignment search: sums every permutation's costs from an
// external table and reports the minimum total and how many permutations reach it.
module jam_search
    import jam_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned COST_W = 7,
    parameter int unsigned IDX_W  = (clog2(N) < 1) ? 1 : clog2(N),
    parameter int unsigned SUM_W  = COST_W + clog2(N),
    parameter int unsigned MC_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    output logic              Busy,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic [MC_W-1:0]   MatchCount,
    output logic [SUM_W-1:0]  MinCost,
    output logic              Valid
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("jam_search: N must be in 2..8");
    end
    if (factorial(N) >= (64'd1 << MC_W)) begin : g_bad_mc_w
        $error("jam_search: MC_W too narrow to hold N!");
    end

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    state_t                  state, state_nx;
    logic [N-1:0][IDX_W-1:0] seq, seq_succ;
    logic                    seq_last;
    logic [IDX_W-1:0]        k;
    logic [SUM_W-1:0]        acc, best;
    logic [MC_W-1:0]         cnt;

    jam_next_perm #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_next_perm (
        .seq      (seq),
        .seq_next (seq_succ),
        .last     (seq_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (Start) state_nx = ST_CAL;
            ST_CAL:   if (k == K_LAST) state_nx = ST_CHECK;
            ST_CHECK: state_nx = ST_NEXT;
            ST_NEXT:  state_nx = seq_last ? ST_DONE : ST_CAL;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign Busy  = (state != ST_IDLE);
    assign Valid = (state == ST_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < N; i++) seq[i] <= IDX_W'(i);
            k          <= '0;
            acc        <= '0;
            best       <= '1;
            cnt        <= '0;
            W          <= '0;
            J          <= '0;
            MinCost    <= '0;
            MatchCount <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        for (int unsigned i = 0; i < N; i++) seq[i] <= IDX_W'(i);
                        k    <= '0;
                        acc  <= '0;
                        best <= '1;
                        cnt  <= '0;
                        W    <= '0;
                        J    <= '0;
                    end
                end
                ST_CAL: begin
                    acc <= acc + SUM_W'(Cost);
                    if (k != K_LAST) begin
                        k <= k + 1'b1;
                        W <= k + 1'b1;
                        J <= seq[k + 1'b1];
                    end
                end
                ST_CHECK: begin
                    if (acc < best) begin
                        best <= acc;
                        cnt  <= MC_W'(1);
                    end else if (acc == best) begin
                        cnt  <= cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (seq_last) begin
                        // Results are loaded here so they are already visible in the Valid cycle.
                        MinCost    <= best;
                        MatchCount <= cnt;
                    end else begin
                        seq <= seq_succ;
                        acc <= '0;
                        k   <= '0;
                        W   <= '0;
                        J   <= seq_succ[0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_search.sv
// Directed bench for jam_search at N=3/4/5 plus standalone jam_next_perm vectors.
module tb_jam_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic [2:0] rst_bus, start_bus, busy_bus, valid_bus;

    logic [1:0]  w3, j3;
    logic [6:0]  cost3;
    logic [15:0] mc3;
    logic [8:0]  min3;
    int          mode3;

    logic [1:0]  w4, j4;
    logic [6:0]  cost4;
    logic [15:0] mc4;
    logic [8:0]  min4;
    int          mode4;

    logic [2:0]  w5, j5;
    logic [6:0]  cost5;
    logic [15:0] mc5;
    logic [9:0]  min5;

    always_comb cost3 = (mode3 == 0) ? 7'd1 : 7'(w3 * 3 + j3 + 1);
    always_comb cost4 = (mode4 == 0) ? ((j4 == 2'(3 - w4)) ? 7'd0 : 7'd5) : 7'(w4);
    always_comb cost5 = 7'(j5);

    jam_search #(.N(3)) u_dut3 (
        .CLK(clk), .RST(rst_bus[0]), .Start(start_bus[0]), .Busy(busy_bus[0]),
        .W(w3), .J(j3), .Cost(cost3), .MatchCount(mc3), .MinCost(min3), .Valid(valid_bus[0])
    );

    jam_search #(.N(4)) u_dut4 (
        .CLK(clk), .RST(rst_bus[1]), .Start(start_bus[1]), .Busy(busy_bus[1]),
        .W(w4), .J(j4), .Cost(cost4), .MatchCount(mc4), .MinCost(min4), .Valid(valid_bus[1])
    );

    jam_search #(.N(5)) u_dut5 (
        .CLK(clk), .RST(rst_bus[2]), .Start(start_bus[2]), .Busy(busy_bus[2]),
        .W(w5), .J(j5), .Cost(cost5), .MatchCount(mc5), .MinCost(min5), .Valid(valid_bus[2])
    );

    logic [3:0][1:0] np_in, np_out, np_exp;
    logic            np_last;

    jam_next_perm #(.N(4), .IDX_W(2)) u_np (
        .seq(np_in), .seq_next(np_out), .last(np_last)
    );

    // Cycle 1 is the cycle after the Start edge; lat is the cycle in which Valid is seen.
    task automatic run(input logic [1:0] sel, input int restart_at, input int limit,
                       output int lat, output int pulses,
                       output logic busy_first, output logic busy_after);
        lat        = 0;
        pulses     = 0;
        busy_first = 1'b0;
        busy_after = 1'b1;
        @(negedge clk);
        start_bus[sel] = 1'b1;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            start_bus[sel] = (cyc == restart_at);
            if (cyc == 1) busy_first = busy_bus[sel];
            if (valid_bus[sel]) begin
                pulses++;
                if (lat == 0) lat = cyc;
            end
            if (lat != 0 && cyc == lat + 1) busy_after = busy_bus[sel];
        end
        start_bus[sel] = 1'b0;
    endtask

    initial begin
        int   lat, pulses, vcount;
        logic bf, ba;

        rst_bus   = '1;
        start_bus = '0;
        mode3     = 0;
        mode4     = 0;
        np_in     = '0;
        repeat (3) @(negedge clk);
        check("rst_w",     32'(w3), 0);
        check("rst_j",     32'(j3), 0);
        check("rst_mc",    32'(mc3), 0);
        check("rst_min",   32'(min3), 0);
        check("rst_valid", 32'(valid_bus), 0);
        check("rst_busy",  32'(busy_bus), 0);
        rst_bus = '0;

        // N=3, unit costs
        run(2'd0, 0, 40, lat, pulses, bf, ba);
        check("n3_lat", lat, 31);
        check("n3_min", 32'(min3), 3);
        check("n3_mc", 32'(mc3), 6);
        check("n3_pulses", pulses, 1);
        check("n3_busy_first", 32'(bf), 1);
        check("n3_busy_after", 32'(ba), 0);

        // N=3, every permutation sums to 15; run twice without reset
        mode3 = 1;
        run(2'd0, 0, 40, lat, pulses, bf, ba);
        check("n3b_min", 32'(min3), 15);
        check("n3b_mc", 32'(mc3), 6);
        run(2'd0, 0, 40, lat, pulses, bf, ba);
        check("n3b2_lat", lat, 31);
        check("n3b2_min", 32'(min3), 15);
        check("n3b2_mc", 32'(mc3), 6);

        // N=3, extra Start in cycle 10 must be ignored
        mode3 = 0;
        run(2'd0, 10, 40, lat, pulses, bf, ba);
        check("n3r_lat", lat, 31);
        check("n3r_pulses", pulses, 1);
        check("n3r_min", 32'(min3), 3);
        check("n3r_mc", 32'(mc3), 6);

        // N=4, only the last permutation (3,2,1,0) costs 0
        mode4 = 0;
        run(2'd1, 0, 160, lat, pulses, bf, ba);
        check("n4a_lat", lat, 145);
        check("n4a_min", 32'(min4), 0);
        check("n4a_mc", 32'(mc4), 1);

        // N=4, cost=w gives 6 for all 24 permutations
        mode4 = 1;
        run(2'd1, 0, 160, lat, pulses, bf, ba);
        check("n4b_min", 32'(min4), 6);
        check("n4b_mc", 32'(mc4), 24);

        // N=4, reset during CAL of the 5th permutation (0,3,1,2)
        @(negedge clk);
        start_bus[1] = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            start_bus[1] = 1'b0;
            if (cyc == 25) begin
                check("n4r_w_c25", 32'(w4), 0);
                check("n4r_j_c25", 32'(j4), 0);
            end
            if (cyc == 26) begin
                check("n4r_w_c26", 32'(w4), 1);
                check("n4r_j_c26", 32'(j4), 3);
                check("n4r_busy_c26", 32'(busy_bus[1]), 1);
            end
        end
        rst_bus[1] = 1'b1;
        @(negedge clk);
        rst_bus[1] = 1'b0;
        check("n4r_busy", 32'(busy_bus[1]), 0);
        check("n4r_valid", 32'(valid_bus[1]), 0);
        check("n4r_w", 32'(w4), 0);
        check("n4r_j", 32'(j4), 0);
        check("n4r_mc", 32'(mc4), 0);
        check("n4r_min", 32'(min4), 0);
        vcount = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (valid_bus[1]) vcount++;
        end
        check("n4r_no_valid", vcount, 0);
        mode4 = 0;
        run(2'd1, 0, 160, lat, pulses, bf, ba);
        check("n4r2_lat", lat, 145);
        check("n4r2_min", 32'(min4), 0);
        check("n4r2_mc", 32'(mc4), 1);

        // N=5, cost=j gives 10 for all 120 permutations
        run(2'd2, 0, 860, lat, pulses, bf, ba);
        check("n5_lat", lat, 841);
        check("n5_min", 32'(min5), 10);
        check("n5_mc", 32'(mc5), 120);
        check("n5_pulses", pulses, 1);

        // Successor permutation vectors (element 0 first)
        np_in[0] = 2'd0; np_in[1] = 2'd1; np_in[2] = 2'd2; np_in[3] = 2'd3;
        np_exp[0] = 2'd0; np_exp[1] = 2'd1; np_exp[2] = 2'd3; np_exp[3] = 2'd2;
        #1;
        check("np_0123", 32'(np_out), 32'(np_exp));
        check("np_0123_last", 32'(np_last), 0);
        np_in[0] = 2'd0; np_in[1] = 2'd3; np_in[2] = 2'd2; np_in[3] = 2'd1;
        np_exp[0] = 2'd1; np_exp[1] = 2'd0; np_exp[2] = 2'd2; np_exp[3] = 2'd3;
        #1;
        check("np_0321", 32'(np_out), 32'(np_exp));
        np_in[0] = 2'd1; np_in[1] = 2'd3; np_in[2] = 2'd2; np_in[3] = 2'd0;
        np_exp[0] = 2'd2; np_exp[1] = 2'd0; np_exp[2] = 2'd1; np_exp[3] = 2'd3;
        #1;
        check("np_1320", 32'(np_out), 32'(np_exp));
        np_in[0] = 2'd3; np_in[1] = 2'd2; np_in[2] = 2'd1; np_in[3] = 2'd0;
        #1;
        check("np_3210_last", 32'(np_last), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
